exe_wb_arbiter: RTL and testbench

Writeback merge stage directly downstream of the ALU, 2-stage multiplier and iterative divider in the execute stage. It accepts one exe_wb_scalar_instr_t per source per cycle and drives the single scalar writeback port. ALU and MUL results are buffered in small FIFOs because those units cannot stall; the divider is held through a valid/ready handshake.

---
 rtl/drac_pkg.sv | 26 ++
 rtl/wb_src_fifo.sv | 67 ++++++
 rtl/exe_wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_exe_wb_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared execute/writeback types: the scalar writeback instruction and the
// writeback source identifiers used by the round-robin arbiter.
package drac_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] result;
        logic [4:0]  rd;
        logic [5:0]  prd;
        logic        regfile_we;
        logic [5:0]  gl_index;
    } exe_wb_scalar_instr_t;

    typedef logic [1:0] wb_src_t;

    localparam wb_src_t WB_SRC_ALU = 2'd0;
    localparam wb_src_t WB_SRC_MUL = 2'd1;
    localparam wb_src_t WB_SRC_DIV = 2'd2;

    // Next source in round-robin order, wrapping DIV back to ALU.
    function automatic wb_src_t wb_src_next(input wb_src_t src);
        return (src == WB_SRC_DIV) ? WB_SRC_ALU : wb_src_t'(src + 2'd1);
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Result buffer for a non-stallable execute unit; FIFO_DEPTH must be a power
// of two so the read/write pointers wrap naturally.
module wb_src_fifo
    import drac_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         flush,
    input  logic                         push,
    input  exe_wb_scalar_instr_t         push_data,
    input  logic                         pop,
    output exe_wb_scalar_instr_t         head,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         full,
    output logic                         empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    exe_wb_scalar_instr_t mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     cnt_q;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO may still accept when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt_q;

    // NOTE: storage is deliberately not reset; occupancy is defined by the
    // pointers and count alone, so stale entries are never observed.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/exe_wb_arbiter.sv
// Scalar writeback arbiter: round-robin merge of ALU and MUL (FIFO-buffered)
// and DIV (valid/ready). Define WB_ARB_PERF_CNT_EN to enable the conflict counter.
module exe_wb_arbiter
    import drac_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 flush_i,
    input  exe_wb_scalar_instr_t alu_instr_i,
    input  exe_wb_scalar_instr_t mul_instr_i,
    input  exe_wb_scalar_instr_t div_instr_i,
    output logic                 div_ready_o,
    output logic                 alu_stall_o,
    output logic                 mul_stall_o,
    output exe_wb_scalar_instr_t instruction_o,
    output logic                 overflow_o,
    output logic [CNT_W-1:0]     conflict_cnt_o
);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    exe_wb_scalar_instr_t alu_head, mul_head, alu_entry, mul_entry, grant_entry, instr_q;
    logic [FCNT_W-1:0]    alu_count, mul_count;
    logic                 alu_full, alu_empty, mul_full, mul_empty;
    logic [2:0]           req;
    wb_src_t              rr_q, grant, cand;
    logic                 grant_valid;
    logic                 gnt_alu, gnt_mul, alu_push, alu_pop, mul_push, mul_pop;
    logic                 drop, overflow_q;

    // An empty FIFO is bypassed so an uncontended result costs one cycle.
    assign alu_entry = alu_empty ? alu_instr_i : alu_head;
    assign mul_entry = mul_empty ? mul_instr_i : mul_head;
    assign req       = {div_instr_i.valid,
                        !mul_empty || mul_instr_i.valid,
                        !alu_empty || alu_instr_i.valid};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant       = rr_q;
        grant_valid = 1'b0;
        cand        = rr_q;
        for (int i = 0; i < 3; i++) begin
            if (!grant_valid && req[cand]) begin
                grant       = cand;
                grant_valid = 1'b1;
            end
            cand = wb_src_next(cand);
        end
    end

    always_comb begin
        case (grant)
            WB_SRC_ALU: grant_entry = alu_entry;
            WB_SRC_MUL: grant_entry = mul_entry;
            default:    grant_entry = div_instr_i;
        endcase
    end

    assign gnt_alu     = grant_valid && (grant == WB_SRC_ALU) && !flush_i;
    assign gnt_mul     = grant_valid && (grant == WB_SRC_MUL) && !flush_i;
    assign div_ready_o = grant_valid && (grant == WB_SRC_DIV) && !flush_i;

    assign alu_pop  = gnt_alu && !alu_empty;
    assign mul_pop  = gnt_mul && !mul_empty;
    assign alu_push = alu_instr_i.valid && !flush_i && !(gnt_alu && alu_empty);
    assign mul_push = mul_instr_i.valid && !flush_i && !(gnt_mul && mul_empty);
    assign drop     = (alu_push && alu_full && !alu_pop) || (mul_push && mul_full && !mul_pop);

    wb_src_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .flush     (flush_i),
        .push      (alu_push),
        .push_data (alu_instr_i),
        .pop       (alu_pop),
        .head      (alu_head),
        .count     (alu_count),
        .full      (alu_full),
        .empty     (alu_empty)
    );

    wb_src_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_mul_fifo (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .flush     (flush_i),
        .push      (mul_push),
        .push_data (mul_instr_i),
        .pop       (mul_pop),
        .head      (mul_head),
        .count     (mul_count),
        .full      (mul_full),
        .empty     (mul_empty)
    );

    // MUL threshold is one lower to absorb the two multiplier stages in flight.
    assign alu_stall_o = (alu_count >= FCNT_W'(FIFO_DEPTH - 1));
    assign mul_stall_o = (mul_count >= FCNT_W'(FIFO_DEPTH - 2));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            instr_q <= '0;
            rr_q    <= WB_SRC_ALU;
        end else if (flush_i) begin
            instr_q.valid <= 1'b0;
            rr_q          <= WB_SRC_ALU;
        end else if (grant_valid) begin
            instr_q <= grant_entry;
            rr_q    <= wb_src_next(grant);
        end else begin
            instr_q.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign instruction_o = instr_q;
    assign overflow_o    = overflow_q;

`ifdef WB_ARB_PERF_CNT_EN
    logic             multi_req;
    logic [CNT_W-1:0] conflict_q;

    assign multi_req = (req[0] && req[1]) || (req[0] && req[2]) || (req[1] && req[2]);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            conflict_q <= '0;
        end else if (!flush_i && multi_req && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_q <= conflict_q + CNT_W'(1);
        end
    end

    assign conflict_cnt_o = conflict_q;
`else
    assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// Self-checking bench for exe_wb_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_exe_wb_arbiter;
    import drac_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic                 clk_i = 1'b0;
    logic                 rstn_i;
    logic                 flush_i;
    exe_wb_scalar_instr_t alu_instr_i, mul_instr_i, div_instr_i, instruction_o;
    logic                 div_ready_o, alu_stall_o, mul_stall_o, overflow_o;
    logic [CNT_W-1:0]     conflict_cnt_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-source queues, a round-robin pointer and sticky flags.
    exe_wb_scalar_instr_t alu_q[$];
    exe_wb_scalar_instr_t mul_q[$];
    int                   rr;
    bit                   m_ovf;
    longint               m_conf;
    exe_wb_scalar_instr_t m_out;

    logic obs_ready, obs_alu_stall, obs_mul_stall;
    int   last_g;

    exe_wb_scalar_instr_t idle = '0;

    exe_wb_arbiter #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .flush_i        (flush_i),
        .alu_instr_i    (alu_instr_i),
        .mul_instr_i    (mul_instr_i),
        .div_instr_i    (div_instr_i),
        .div_ready_o    (div_ready_o),
        .alu_stall_o    (alu_stall_o),
        .mul_stall_o    (mul_stall_o),
        .instruction_o  (instruction_o),
        .overflow_o     (overflow_o),
        .conflict_cnt_o (conflict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exe_wb_scalar_instr_t rand_instr();
        exe_wb_scalar_instr_t t;
        t.valid      = 1'b1;
        t.pc         = {$urandom, $urandom};
        t.result     = {$urandom, $urandom};
        t.rd         = 5'($urandom);
        t.prd        = 6'($urandom);
        t.regfile_we = 1'($urandom);
        t.gl_index   = 6'($urandom);
        return t;
    endfunction

    function automatic logic [CNT_W-1:0] conf_exp(input longint n);
`ifdef WB_ARB_PERF_CNT_EN
        return CNT_W'(n);
`else
        return (n < 0) ? CNT_W'(1) : '0;
`endif
    endfunction

    task automatic model_reset();
        alu_q.delete();
        mul_q.delete();
        rr     = 0;
        m_ovf  = 0;
        m_conf = 0;
        m_out  = '0;
    endtask

    task automatic drive_idle();
        alu_instr_i = '0;
        mul_instr_i = '0;
        div_instr_i = '0;
        flush_i     = 1'b0;
    endtask

    task automatic apply_reset();
        drive_idle();
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        model_reset();
    endtask

    // One clock: drive at negedge, compare combinational outputs, advance the
    // model, then compare registered outputs just after the rising edge.
    task automatic cycle(input exe_wb_scalar_instr_t a, input exe_wb_scalar_instr_t m,
                         input exe_wb_scalar_instr_t d, input logic fl);
        logic [2:0]           req;
        int                   g;
        int                   nreq;
        bit                   byp_a, byp_m;
        exe_wb_scalar_instr_t tmp;
        @(negedge clk_i);
        alu_instr_i = a;
        mul_instr_i = m;
        div_instr_i = d;
        flush_i     = fl;
        #1;
        req[0] = (alu_q.size() > 0) || a.valid;
        req[1] = (mul_q.size() > 0) || m.valid;
        req[2] = d.valid;
        nreq   = int'(req[0]) + int'(req[1]) + int'(req[2]);
        g = -1;
        for (int k = 0; k < 3; k++) if (g < 0 && req[(rr + k) % 3]) g = (rr + k) % 3;
        if (fl) g = -1;
        obs_ready     = div_ready_o;
        obs_alu_stall = alu_stall_o;
        obs_mul_stall = mul_stall_o;
        checks++;
        if (div_ready_o !== (g == 2)) begin
            errors++;
            $display("FAIL div_ready t=%0t got %b want %b", $time, div_ready_o, (g == 2));
        end
        checks++;
        if (alu_stall_o !== (alu_q.size() >= DEPTH - 1)) begin
            errors++;
            $display("FAIL alu_stall t=%0t got %b want %b", $time, alu_stall_o, (alu_q.size() >= DEPTH - 1));
        end
        checks++;
        if (mul_stall_o !== (mul_q.size() >= DEPTH - 2)) begin
            errors++;
            $display("FAIL mul_stall t=%0t got %b want %b", $time, mul_stall_o, (mul_q.size() >= DEPTH - 2));
        end

        if (fl) begin
            alu_q.delete();
            mul_q.delete();
            rr          = 0;
            m_out.valid = 1'b0;
        end else begin
            if (nreq >= 2 && m_conf < 64'hFFFF_FFFF) m_conf++;
            byp_a       = (g == 0) && (alu_q.size() == 0);
            byp_m       = (g == 1) && (mul_q.size() == 0);
            m_out.valid = 1'b0;
            if (g == 0) begin
                if (byp_a) m_out = a;
                else begin tmp = alu_q.pop_front(); m_out = tmp; end
            end else if (g == 1) begin
                if (byp_m) m_out = m;
                else begin tmp = mul_q.pop_front(); m_out = tmp; end
            end else if (g == 2) begin
                m_out = d;
            end
            if (a.valid && !byp_a) begin
                if (alu_q.size() < DEPTH) alu_q.push_back(a);
                else m_ovf = 1;
            end
            if (m.valid && !byp_m) begin
                if (mul_q.size() < DEPTH) mul_q.push_back(m);
                else m_ovf = 1;
            end
            if (g >= 0) rr = (g + 1) % 3;
        end
        last_g = g;

        @(posedge clk_i);
        #1;
        checks++;
        if (instruction_o.valid !== m_out.valid) begin
            errors++;
            $display("FAIL wb_valid t=%0t got %b want %b", $time, instruction_o.valid, m_out.valid);
        end else if (m_out.valid && instruction_o !== m_out) begin
            errors++;
            $display("FAIL wb_data t=%0t got %h want %h", $time, instruction_o, m_out);
        end
        checks++;
        if (overflow_o !== m_ovf) begin
            errors++;
            $display("FAIL overflow t=%0t got %b want %b", $time, overflow_o, m_ovf);
        end
        checks++;
        if (conflict_cnt_o !== conf_exp(m_conf)) begin
            errors++;
            $display("FAIL conflict_cnt t=%0t got %0d want %0d", $time, conflict_cnt_o, conf_exp(m_conf));
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rstn_i = 1'b0;
        #1;
        checks++;
        if (instruction_o !== '0 || div_ready_o !== 1'b0 || alu_stall_o !== 1'b0 ||
            mul_stall_o !== 1'b0 || overflow_o !== 1'b0 || conflict_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset_state got wb=%h rdy=%b st=%b%b ovf=%b cnt=%0d want all zero",
                     instruction_o, div_ready_o, alu_stall_o, mul_stall_o, overflow_o, conflict_cnt_o);
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
        model_reset();
    endtask

    task automatic test_single_mul();
        exe_wb_scalar_instr_t m;
        apply_reset();
        m        = rand_instr();
        m.result = 64'h1234;
        m.prd    = 6'd5;
        cycle(idle, m, idle, 1'b0);
        checks++;
        if (instruction_o.valid !== 1'b1 || instruction_o.result !== 64'h1234 || instruction_o.prd !== 6'd5) begin
            errors++;
            $display("FAIL single_mul got v=%b res=%h prd=%0d want v=1 res=1234 prd=5",
                     instruction_o.valid, instruction_o.result, instruction_o.prd);
        end
        cycle(idle, idle, idle, 1'b0);
        checks++;
        if (obs_mul_stall !== 1'b0 || instruction_o.valid !== 1'b0) begin
            errors++;
            $display("FAIL single_mul_after got stall=%b v=%b want 0 0", obs_mul_stall, instruction_o.valid);
        end
    endtask

    task automatic test_triple();
        exe_wb_scalar_instr_t a, m, d, a2;
        logic [2:0]           hist;
        apply_reset();
        a = rand_instr(); m = rand_instr(); d = rand_instr();
        cycle(a, m, d, 1'b0);
        hist[0] = obs_ready;
        checks++;
        if (instruction_o !== a) begin
            errors++;
            $display("FAIL triple_alu got %h want %h", instruction_o, a);
        end
        cycle(idle, idle, d, 1'b0);
        hist[1] = obs_ready;
        checks++;
        if (instruction_o !== m) begin
            errors++;
            $display("FAIL triple_mul got %h want %h", instruction_o, m);
        end
        cycle(idle, idle, d, 1'b0);
        hist[2] = obs_ready;
        checks++;
        if (instruction_o !== d) begin
            errors++;
            $display("FAIL triple_div got %h want %h", instruction_o, d);
        end
        checks++;
        if (hist !== 3'b100) begin
            errors++;
            $display("FAIL triple_ready got %b want 100", hist);
        end
        checks++;
        if (conflict_cnt_o !== conf_exp(2)) begin
            errors++;
            $display("FAIL triple_conflict got %0d want %0d", conflict_cnt_o, conf_exp(2));
        end
        a2 = rand_instr();
        cycle(a2, rand_instr(), rand_instr(), 1'b0);
        checks++;
        if (instruction_o !== a2) begin
            errors++;
            $display("FAIL triple_rr_wrap got %h want %h", instruction_o, a2);
        end
    endtask

    task automatic test_div_fairness();
        exe_wb_scalar_instr_t d;
        int div_cycle, stall_cycle;
        apply_reset();
        d = rand_instr();
        div_cycle = -1;
        stall_cycle = -1;
        for (int c = 0; c < 6; c++) begin
            cycle(rand_instr(), rand_instr(), d, 1'b0);
            if (obs_ready && div_cycle < 0) div_cycle = c;
            if (obs_mul_stall && stall_cycle < 0) stall_cycle = c;
            if (last_g == 2) d = rand_instr();
        end
        checks++;
        if (div_cycle !== 2) begin
            errors++;
            $display("FAIL div_fair got cycle %0d want 2", div_cycle);
        end
        checks++;
        if (stall_cycle !== 3) begin
            errors++;
            $display("FAIL mul_stall_rise got cycle %0d want 3", stall_cycle);
        end
    endtask

    task automatic test_overflow();
        exe_wb_scalar_instr_t d;
        apply_reset();
        d = rand_instr();
        for (int c = 0; c < 8; c++) begin
            cycle(rand_instr(), rand_instr(), d, 1'b0);
            if (last_g == 2) d = rand_instr();
        end
        checks++;
        if (overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set got %b want 1", overflow_o);
        end
        for (int c = 0; c < 14; c++) begin
            cycle(idle, idle, d, 1'b0);
            if (last_g == 2) d = idle;
        end
        checks++;
        if (instruction_o.valid !== 1'b0 || obs_alu_stall !== 1'b0 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_drain got v=%b stall=%b ovf=%b want 0 0 1",
                     instruction_o.valid, obs_alu_stall, overflow_o);
        end
    endtask

    task automatic test_flush();
        exe_wb_scalar_instr_t d, fa, a2;
        apply_reset();
        d = rand_instr();
        for (int c = 0; c < 4; c++) begin
            cycle(rand_instr(), rand_instr(), d, 1'b0);
            if (last_g == 2) d = rand_instr();
        end
        checks++;
        if (obs_mul_stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_prefill got mul_stall=%b want 1", obs_mul_stall);
        end
        fa        = rand_instr();
        fa.result = 64'hDEAD;
        cycle(fa, idle, d, 1'b1);
        checks++;
        if (obs_ready !== 1'b0 || instruction_o.valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_edge got rdy=%b v=%b want 0 0", obs_ready, instruction_o.valid);
        end
        cycle(idle, idle, idle, 1'b0);
        checks++;
        if (obs_alu_stall !== 1'b0 || obs_mul_stall !== 1'b0 || instruction_o.valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_after got st=%b%b v=%b want 00 0", obs_alu_stall, obs_mul_stall, instruction_o.valid);
        end
        a2 = rand_instr();
        cycle(a2, rand_instr(), rand_instr(), 1'b0);
        checks++;
        if (instruction_o !== a2) begin
            errors++;
            $display("FAIL flush_rr got %h want %h", instruction_o, a2);
        end
    endtask

    task automatic test_async_reset();
        exe_wb_scalar_instr_t d, a;
        apply_reset();
        d = rand_instr();
        for (int c = 0; c < 5; c++) begin
            cycle(rand_instr(), rand_instr(), d, 1'b0);
            if (last_g == 2) d = rand_instr();
        end
        @(negedge clk_i);
        drive_idle();
        #2;
        rstn_i = 1'b0;
        #1;
        checks++;
        if (instruction_o !== '0 || div_ready_o !== 1'b0 || alu_stall_o !== 1'b0 ||
            mul_stall_o !== 1'b0 || overflow_o !== 1'b0 || conflict_cnt_o !== '0) begin
            errors++;
            $display("FAIL async_reset got wb=%h rdy=%b st=%b%b ovf=%b cnt=%0d want all zero",
                     instruction_o, div_ready_o, alu_stall_o, mul_stall_o, overflow_o, conflict_cnt_o);
        end
        #1;
        rstn_i = 1'b1;
        model_reset();
        a = rand_instr();
        cycle(a, idle, idle, 1'b0);
        checks++;
        if (instruction_o !== a) begin
            errors++;
            $display("FAIL post_reset_first got %h want %h", instruction_o, a);
        end
    endtask

    task automatic test_random();
        exe_wb_scalar_instr_t a, m, d;
        logic                 fl;
        apply_reset();
        d = idle;
        for (int c = 0; c < 600; c++) begin
            a  = ($urandom_range(1, 0) == 1) ? rand_instr() : idle;
            m  = ($urandom_range(1, 0) == 1) ? rand_instr() : idle;
            if (!d.valid && $urandom_range(2, 0) == 0) d = rand_instr();
            fl = ($urandom_range(31, 0) == 0);
            cycle(a, m, d, fl);
            if (last_g == 2 || fl) d = idle;
        end
    endtask

    initial begin
        rstn_i = 1'b1;
        drive_idle();
        #2;
        test_reset();
        test_single_mul();
        test_triple();
        test_div_fairness();
        test_overflow();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
